// File: rtl/pipeline_pkg.sv
// Types and constants shared by the front-end pipeline stages.
// The fetch logic carries instruction words through without decoding them.
package pipeline_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ITYPE = 6'b000001;
  localparam logic [5:0] OPC_JTYPE = 6'b000010;

  typedef enum logic [1:0] {
    REQ        = 2'd0,
    WAIT       = 2'd1,
    FLUSH_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs for decode.
// A flush empties the queue and wins over a push in the same cycle.
module fetch_buffer
  import pipeline_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, single-outstanding imem request/response
// handling, redirect flushing and buffered hand-off to decode.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2,
  parameter int              PC_STEP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [XLEN-1:0]    id_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic             req_fire;
  logic             rsp_accept;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_empty;
  logic             buf_full;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_entry;
  fetch_entry_t     buf_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // A request accepted alongside a redirect is already stale, so its
  // response must be swallowed in FLUSH_WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ: begin
        if (req_fire) state_d = redirect_valid ? FLUSH_WAIT : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid)      state_d = REQ;
        else if (redirect_valid) state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    rsp_accept     = 1'b0;
    unique case (state_q)
      REQ:     imem_req_valid = rst_n && (buf_count < CNT_W'(BUF_DEPTH));
      WAIT:    rsp_accept     = imem_rsp_valid && !redirect_valid;
      default: ;
    endcase
  end

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc_q;

  always_comb begin
    req_pc_d = req_fire ? pc_q : req_pc_q;
    if (redirect_valid)  pc_d = align_pc(redirect_pc);
    else if (req_fire)   pc_d = pc_q + XLEN'(PC_STEP);
    else                 pc_d = pc_q;
  end

  assign buf_push        = rsp_accept;
  assign buf_pop         = id_valid && id_ready;
  assign buf_entry.pc    = req_pc_q;
  assign buf_entry.instr = imem_rsp_data;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (buf_push),
    .entry_i (buf_entry),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .head_o  (buf_head),
    .count_o (buf_count),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  assign id_valid       = !buf_empty;
  assign id_instruction = buf_head.instr;
  assign id_pc          = buf_head.pc;

  // Requests are gated on free space, so a push can never find the queue full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a transaction-level
// model: expected fetch address, outstanding request and decode queue.
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
  localparam int          PC_STEP   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH),
    .PC_STEP   (PC_STEP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Model state
  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_req_addr;
  bit           m_out;
  bit           m_live;
  int           rsp_cnt;
  bit           last_redir;
  int           cyc;
  logic [31:0]  req_log[$];
  logic [31:0]  id_log[$];
  int           req_cyc[$];

  int id_rdy_pct, mem_rdy_pct, rsp_delay, spur_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic cfg(input int idr, input int memr, input int dly, input int spur);
    id_rdy_pct  = idr;
    mem_rdy_pct = memr;
    rsp_delay   = dly;
    spur_pct    = spur;
  endtask

  task automatic clear_logs();
    req_log.delete();
    id_log.delete();
    req_cyc.delete();
  endtask

  // rmode: 0 no redirect, 1 forced, 2 only together with a request handshake, 3 random
  task automatic run_cycle(input int rmode, input logic [31:0] tgt);
    bit           exp_req_v, id_fire, req_fire, rsp_now, redir;
    logic [31:0]  tgt_use;
    fetch_entry_t e;
    @(negedge clk);
    exp_req_v = !m_out && (exp_q.size() < BUF_DEPTH);
    chk("req_valid", imem_req_valid, exp_req_v);
    if (exp_req_v) chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", id_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("id_pc", id_pc, exp_q[0].pc);
      chk("id_instr", id_instruction, exp_q[0].instr);
    end
    id_ready       = ($urandom_range(99) < id_rdy_pct);
    imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
    rsp_now = 1'b0;
    if (m_out) begin
      if (rsp_cnt == 0) rsp_now = 1'b1;
      else rsp_cnt--;
    end else if ($urandom_range(99) < spur_pct) begin
      rsp_now = 1'b1;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = (rsp_now && m_out) ? mem_word(m_req_addr) : $urandom;
    id_fire  = id_ready && (exp_q.size() != 0);
    req_fire = exp_req_v && imem_req_ready;
    case (rmode)
      1:       redir = 1'b1;
      2:       redir = req_fire;
      3:       redir = ($urandom_range(99) < 5);
      default: redir = 1'b0;
    endcase
    tgt_use = tgt;
    if (rmode == 3) tgt_use = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
    redirect_valid = redir;
    redirect_pc    = redir ? tgt_use : $urandom;
    last_redir     = redir;
    @(posedge clk);
    cyc++;
    if (id_fire) begin
      $display("ID   cyc=%0d pc=%h instr=%h", cyc, exp_q[0].pc, exp_q[0].instr);
      id_log.push_back(exp_q[0].pc);
      void'(exp_q.pop_front());
    end
    if (rsp_now && m_out) begin
      if (m_live && !redir) begin
        e.pc    = m_req_addr;
        e.instr = mem_word(m_req_addr);
        exp_q.push_back(e);
      end
      m_out = 1'b0;
    end
    if (req_fire) begin
      m_out      = 1'b1;
      m_live     = !redir;
      m_req_addr = m_pc;
      req_log.push_back(m_pc);
      req_cyc.push_back(cyc);
      m_pc       = m_pc + PC_STEP;
      rsp_cnt    = (rsp_delay < 0) ? int'($urandom_range(3)) : rsp_delay;
    end
    if (redir) begin
      exp_q.delete();
      m_live = 1'b0;
      m_pc   = tgt_use & ~32'h3;
    end
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic reset_model();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_out   = 1'b0;
    m_live  = 1'b0;
    rsp_cnt = 0;
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instruction, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] p0, i0;
  bit          hit;

  initial begin
    rst_n = 1'b0;
    drive_idle();
    reset_model();
    cyc = 0;
    last_redir = 1'b0;
    cfg(100, 100, 0, 0);
    #1;
    chk("por_req_valid", imem_req_valid, 1'b0);
    chk("por_id_valid", id_valid, 1'b0);
    chk("por_id_pc", id_pc, 32'h0);
    chk("por_id_instr", id_instruction, 32'h0);
    chk("por_req_addr", imem_req_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch, always-ready memory and decode
    clear_logs();
    repeat (8) run_cycle(0, 32'h0);
    chk("seq_req0", q_at(req_log, 0), 32'h0);
    chk("seq_req1", q_at(req_log, 1), 32'h4);
    chk("seq_req2", q_at(req_log, 2), 32'h8);
    chk("seq_id0", q_at(id_log, 0), 32'h0);
    chk("seq_id1", q_at(id_log, 1), 32'h4);
    chk("seq_id2", q_at(id_log, 2), 32'h8);
    chk("seq_gap01", (req_cyc.size() > 1) ? 32'(req_cyc[1] - req_cyc[0]) : 32'h0, 32'd2);
    chk("seq_gap12", (req_cyc.size() > 2) ? 32'(req_cyc[2] - req_cyc[1]) : 32'h0, 32'd2);

    // Decode stall: buffer fills, fetch stops, head holds
    cfg(0, 100, 0, 0);
    repeat (10) run_cycle(0, 32'h0);
    #1;
    chk("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_id_valid", id_valid, 1'b1);
    p0 = id_pc;
    i0 = id_instruction;
    run_cycle(0, 32'h0);
    #1;
    chk("stall_pc_hold", id_pc, p0);
    chk("stall_instr_hold", id_instruction, i0);
    clear_logs();
    cfg(100, 100, 0, 0);
    repeat (8) run_cycle(0, 32'h0);
    chk("drain0", q_at(id_log, 0), p0);
    chk("drain1", q_at(id_log, 1), p0 + 32'h4);
    chk("resume_addr", q_at(req_log, 0), p0 + 32'h8);

    // Redirect while waiting for a slow response
    cfg(100, 100, 3, 0);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (m_out) hit = 1'b1;
      else run_cycle(0, 32'h0);
    end
    chk("wait_reached", hit, 1'b1);
    run_cycle(1, 32'h0000_0103);
    clear_logs();
    rsp_delay = 0;
    repeat (12) run_cycle(0, 32'h0);
    chk("redir_wait_req", q_at(req_log, 0), 32'h0000_0100);
    chk("redir_wait_id", q_at(id_log, 0), 32'h0000_0100);

    // Redirect coinciding with a request handshake
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      run_cycle(2, 32'h0000_0200);
      hit = last_redir;
    end
    chk("hs_redirect_seen", hit, 1'b1);
    clear_logs();
    repeat (12) run_cycle(0, 32'h0);
    chk("redir_hs_req", q_at(req_log, 0), 32'h0000_0200);
    chk("redir_hs_id", q_at(id_log, 0), 32'h0000_0200);

    // Wrap-around at the top of the address space
    run_cycle(1, 32'hFFFF_FFFE);
    clear_logs();
    repeat (10) run_cycle(0, 32'h0);
    chk("wrap_req0", q_at(req_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", q_at(req_log, 1), 32'h0000_0000);
    chk("wrap_id0", q_at(id_log, 0), 32'hFFFF_FFFC);
    chk("wrap_id1", q_at(id_log, 1), 32'h0000_0000);

    // Reset in WAIT with one entry buffered
    cfg(0, 100, 2, 0);
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      if (m_out && exp_q.size() == 1) hit = 1'b1;
      else run_cycle(0, 32'h0);
    end
    chk("wait_one_buffered", hit, 1'b1);
    do_reset_mid();
    clear_logs();
    cfg(100, 100, 0, 0);
    repeat (3) run_cycle(0, 32'h0);
    chk("post_reset_addr", q_at(req_log, 0), RESET_PC);

    // Randomized traffic with redirects and spurious responses
    cfg(70, 60, -1, 10);
    repeat (1500) run_cycle(3, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage. It generates the PC, requests instruction words from instruction memory over a valid/ready request channel, and accepts them on a valid-only response channel. Fetched {pc, instruction} pairs are buffered and handed to the decode stage over a valid/ready interface. A redirect input (branch/jump resolution) flushes buffered and in-flight work and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, fetch buffer entries (power of 2, >=2)
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid (one cycle per accepted request)
imem_rsp_data  input  32  instruction word
id_valid  output  1  instruction available to decode
id_ready  input  1  decode accepts instruction
id_instruction  output  32  instruction to decode
id_pc  output  32  PC of id_instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  restart address; bits [1:0] ignored and forced to 0

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: pc=RESET_PC, state=REQ, buffer empty. imem_req_valid=0 while rst_n=0. id_valid=0, id_instruction=0, id_pc=0, imem_req_addr=RESET_PC.
- At most one request is outstanding.
- FSM states: REQ, WAIT, FLUSH_WAIT.
- REQ:
  - imem_req_valid=1 iff buffer count < BUF_DEPTH. imem_req_addr=pc.
  - On handshake (valid & ready): capture req_pc=pc, pc<=pc+PC_STEP (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go to WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: push {req_pc, imem_rsp_data} into the buffer, go to REQ.
- FLUSH_WAIT: imem_req_valid=0. On imem_rsp_valid: discard the data, go to REQ.
- imem_rsp_valid while in REQ is ignored.
- Redirect has the highest priority, in any state:
  - buffer flushed (id_valid=0 next cycle); pc<=redirect_pc & ~3.
  - REQ without handshake: stay in REQ.
  - REQ with handshake in the same cycle: go to FLUSH_WAIT; the stale response is discarded.
  - WAIT: go to FLUSH_WAIT if no response this cycle. If a response arrives the same cycle, drop it and go to REQ.
  - FLUSH_WAIT: stay, or go to REQ if a response arrives the same cycle.
- Decode interface:
  - id_valid = buffer non-empty; id_instruction/id_pc = buffer head (registered).
  - Pop on id_valid & id_ready.
  - Outputs hold stable while id_valid & !id_ready.
  - Push and pop in the same cycle are both performed.
- Overflow is impossible: a request is issued only when count < BUF_DEPTH with none in flight. A pop in the push cycle frees a slot.
- Latency:
  - Request handshake at cycle n, response at cycle m >= n+1, id_valid high at m+1.
  - Best-case sequential throughput is one instruction per 2 cycles (REQ, WAIT).
- Reset mid-operation: all state clears immediately. Instruction memory shares rst_n, so no pre-reset response arrives after reset release.
- Instructions are not inspected; the block is opcode-agnostic.

Decomposition:
- Shared package pipeline_pkg:
  - XLEN=32, INSTR_W=32
  - opcode constants OPC_RTYPE=6'b000000, OPC_ITYPE=6'b000001, OPC_JTYPE=6'b000010
  - typedef fetch_state_t {REQ, WAIT, FLUSH_WAIT}
  - struct fetch_entry_t {pc, instr}
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t, depth BUF_DEPTH, with push/pop/flush, count, empty, full. Flush dominates push in the same cycle.

Test Plan:
- Reset release, imem always ready, 1-cycle response, id_ready=1 -> addresses 0x0, 0x4, 0x8 issued on alternating cycles; id_pc sequence 0x0, 0x4, 0x8 with matching data.
- id_ready=0 for 10 cycles -> exactly 2 entries buffered; imem_req_valid drops to 0; id_instruction/id_pc stay stable. Raising id_ready drains entries in order, then fetch resumes at 0x8.
- Redirect to 0x0000_0103 while in WAIT, response arrives 3 cycles later -> response discarded; next request addr=0x0000_0100; first id_pc=0x100.
- Redirect on the same cycle as a request handshake -> one following response discarded; no instruction from the old path reaches id_valid.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- rst_n asserted mid-WAIT with 1 buffered entry -> id_valid=0 and imem_req_valid=0 immediately; after release, first request addr=RESET_PC.
